// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR with one shared signed MAC, one tap per clock
// Optional FIR_MAC_SAT_EN: saturate the final sum to the OUT_W range instead of wrapping.
module fir_mac_sequencer #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [DATA_W-1:0]  x_in,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [OUT_W-1:0]   y_out,
    output logic                      busy
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int ACC_W  = OUT_W + IDX_W;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [IDX_W:0]   TAPS_C   = (IDX_W + 1)'(TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_HOLD
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  line_q [TAPS];
    logic signed [DATA_W-1:0]  line_d [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [COEF_W-1:0]  coef_d [TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [OUT_W-1:0]   y_q, y_d;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [OUT_W-1:0]   y_conv;
    logic                      coef_addr_ok;

    assign prod         = line_q[idx_q] * coef_q[idx_q];
    assign acc_sum      = acc_q + ACC_W'(prod);
    assign coef_addr_ok = {1'b0, coef_addr} < TAPS_C;

`ifdef FIR_MAC_SAT_EN
    logic [ACC_W-OUT_W:0] acc_top;

    assign acc_top = acc_sum[ACC_W-1:OUT_W-1];

    // Bits above the OUT_W sign bit must all match it, otherwise clamp toward the sign.
    always_comb begin
        if (acc_top == '0 || acc_top == '1) begin
            y_conv = acc_sum[OUT_W-1:0];
        end else if (acc_sum[ACC_W-1]) begin
            y_conv = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            y_conv = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign y_conv = acc_sum[OUT_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        coef_d  = coef_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;

        case (state_q)
            ST_IDLE: begin
                if (coef_we && coef_addr_ok) begin
                    coef_d[coef_addr] = coef_data;
                end
                if (s_valid) begin
                    line_d[0] = x_in;
                    for (int i = 1; i < TAPS; i++) begin
                        line_d[i] = line_q[i-1];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    y_d     = y_conv;
                    idx_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset leaves coef[0]=1 so an unconfigured filter passes samples straight through.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
                if (i == 0) begin
                    coef_q[i] <= COEF_W'(1);
                end else begin
                    coef_q[i] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            coef_q  <= coef_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
        end
    end

    assign s_ready = (state_q == ST_IDLE) && !reset;
    assign m_valid = (state_q == ST_HOLD) && !reset;
    assign busy    = ((state_q == ST_MAC) || (state_q == ST_HOLD)) && !reset;
    assign y_out   = reset ? '0 : y_q;

endmodule
